// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle mult/div sequencer that owns HI/LO, serves mfhi/mflo
// and raises the D-stage stall while an MD operation is in flight.
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  E_MDOp,
  input  logic [31:0] E_A,
  input  logic [31:0] E_B,
  input  logic        D_IsMD,
  output logic        E_Busy,
  output logic [31:0] E_MDResult,
  output logic        D_MDStall,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d, thi_q, thi_d, tlo_q, tlo_d;
  logic          start, is_mul, sgn, neg_a, neg_b;
  logic [31:0]   ua, ub, ub_nz, uq, ur, q, r;
  logic [63:0]   pmag, prod;

  assign start  = (E_MDOp >= 4'd1) && (E_MDOp <= 4'd4);
  assign is_mul = (E_MDOp == 4'd1) || (E_MDOp == 4'd2);
  assign sgn    = (E_MDOp == 4'd1) || (E_MDOp == 4'd3);
  assign neg_a  = sgn & E_A[31];
  assign neg_b  = sgn & E_B[31];
  assign ua     = neg_a ? -E_A : E_A;
  assign ub     = neg_b ? -E_B : E_B;
  // Signed ops run on magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly
  assign ub_nz  = (ub == 32'd0) ? 32'd1 : ub;
  assign uq     = ua / ub_nz;
  assign ur     = ua % ub_nz;
  assign q      = (neg_a ^ neg_b) ? -uq : uq;
  assign r      = neg_a ? -ur : ur;
  assign pmag   = {32'd0, ua} * {32'd0, ub};
  assign prod   = (neg_a ^ neg_b) ? -pmag : pmag;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    thi_d   = thi_q;
    tlo_d   = tlo_q;
    if (state_q == IDLE) begin
      if (start) begin
        state_d = BUSY;
        count_d = is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        // Divide by zero commits the current HI/LO back, i.e. leaves them unchanged
        thi_d   = is_mul ? prod[63:32] : (E_B == 32'd0) ? hi_q : r;
        tlo_d   = is_mul ? prod[31:0]  : (E_B == 32'd0) ? lo_q : q;
      end else begin
        hi_d = (E_MDOp == 4'd5) ? E_A : hi_q;
        lo_d = (E_MDOp == 4'd6) ? E_A : lo_q;
      end
    end else begin
      count_d = count_q - CW'(1);
      if (count_q == CW'(1)) begin
        state_d = IDLE;
        hi_d    = thi_q;
        lo_d    = tlo_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      thi_q   <= '0;
      tlo_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      thi_q   <= thi_d;
      tlo_q   <= tlo_d;
    end
  end

  assign E_Busy     = start | (state_q == BUSY);
  assign D_MDStall  = D_IsMD & E_Busy;
  assign E_MDResult = (E_MDOp == 4'd7) ? hi_q : (E_MDOp == 4'd8) ? lo_q : 32'd0;
  assign HI         = hi_q;
  assign LO         = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed MD operations; a scoreboard checks busy-window length
// and committed HI/LO each time E_Busy falls.
module tb_mdu_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  E_MDOp = 4'd0;
  logic [31:0] E_A = 32'd0, E_B = 32'd0;
  logic        D_IsMD = 1'b0;
  logic        E_Busy, D_MDStall;
  logic [31:0] E_MDResult, HI, LO;

  typedef struct {
    string       name;
    int          len;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   busy_run = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .E_MDOp(E_MDOp), .E_A(E_A), .E_B(E_B),
    .D_IsMD(D_IsMD), .E_Busy(E_Busy), .E_MDResult(E_MDResult),
    .D_MDStall(D_MDStall), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Monitor: a falling E_Busy marks the end of an operation
  always @(negedge clk) begin
    if (E_Busy) busy_run++;
    else if (busy_run > 0) begin
      if (exp_q.size() == 0) chk("unexpected_completion", 32'(busy_run), 32'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk({e.name, "_len"}, 32'(busy_run), 32'(e.len));
        chk({e.name, "_hi"}, HI, e.hi);
        chk({e.name, "_lo"}, LO, e.lo);
      end
      busy_run = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one op in cycle 0 and run through cycle n+1, checking the stall each cycle
  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int n, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic dmd);
    exp_q.push_back('{name, n + 1, ehi, elo});
    E_MDOp = op; E_A = a; E_B = b; D_IsMD = dmd;
    for (int c = 0; c <= n + 1; c++) begin
      @(negedge clk);
      if (c == 0 || c == n || c == n + 1)
        chk($sformatf("%s_stall_c%0d", name, c), {31'd0, D_MDStall}, {31'd0, dmd && (c <= n)});
      cyc();
      if (c == 0) E_MDOp = 4'd0;
    end
    D_IsMD = 1'b0;
  endtask

  initial begin
    E_MDOp = 4'd7; D_IsMD = 1'b1;
    @(negedge clk);
    chk("rst_busy", {31'd0, E_Busy}, 32'd0);
    chk("rst_stall", {31'd0, D_MDStall}, 32'd0);
    chk("rst_result", E_MDResult, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    reset = 1'b1; E_MDOp = 4'd0; D_IsMD = 1'b0;
    cyc();

    do_op("mult", 4'd1, 32'd3, 32'hFFFFFFFE, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1);
    E_MDOp = 4'd8;
    @(negedge clk);
    chk("mflo_after_mult", E_MDResult, 32'hFFFFFFFA);
    cyc();
    do_op("multu", 4'd2, 32'd3, 32'hFFFFFFFE, 5, 32'h00000002, 32'hFFFFFFFA, 1'b0);
    do_op("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b1);
    do_op("div_negb", 4'd3, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    do_op("divu", 4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
    do_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'd0, 32'h80000000, 1'b0);

    E_MDOp = 4'd5; E_A = 32'h11;
    @(negedge clk);
    chk("mthi_result_zero", E_MDResult, 32'd0);
    cyc();
    E_MDOp = 4'd6; E_A = 32'h22;
    cyc();
    E_MDOp = 4'd7;
    @(negedge clk);
    chk("mfhi", E_MDResult, 32'h11);
    chk("mtlo", LO, 32'h22);
    cyc();
    E_MDOp = 4'd0;
    do_op("div0", 4'd3, 32'd100, 32'd0, 10, 32'h11, 32'h22, 1'b0);

    // Abort a div with reset in cycle 3
    exp_q.push_back('{"div_abort", 3, 32'd0, 32'd0});
    E_MDOp = 4'd3; E_A = 32'd50; E_B = 32'd7;
    cyc();
    E_MDOp = 4'd0;
    cyc();
    cyc();
    reset = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, E_Busy}, 32'd0);
    reset = 1'b1;
    cyc();
    do_op("mult_after", 4'd1, 32'd5, 32'd6, 5, 32'd0, 32'd30, 1'b1);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
